hrm_mmrx: RTL and testbench



---
 rtl/hrm_mmrx_pkg.sv | 27 ++
 rtl/hrm_mmrx_tpram.sv | 29 ++
 rtl/hrm_mmrx.sv | 217 +++++++++++++++++++++
 tb/tb_hrm_mmrx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hrm_mmrx_pkg.sv
// hrm_mmrx_pkg
//   Shared definitions for the HRM MCU receive memory manager:
//   slink word field positions, write FSM state encoding, and the
//   {slot, bank, addr} buffer address composition used by both RAM ports.
package hrm_mmrx_pkg;

  localparam int SOP_BIT = 17;
  localparam int EOP_BIT = 16;
  localparam int PKT_LSB = 8;
  localparam int PKT_MSB = 11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // Buffer RAM address = {slot, bank, word address}; callers size-cast the
  // result down to their RAM address width.
  function automatic logic [31:0] ram_addr(input logic [31:0] slot,
                                           input logic [31:0] bank,
                                           input logic [31:0] addr,
                                           input int          depth_w);
    return (((slot << 1) | bank) << depth_w) | addr;
  endfunction

endpackage

// File: rtl/hrm_mmrx_tpram.sv
// hrm_mmrx_tpram
//   Simple dual-port RAM, one write port and one read port on a common
//   clock, registered read data. Inferred memory, contents not reset.
// Ports:
//   clk    clock
//   we     write enable,  waddr / wdata write address / data
//   re     read enable,   raddr read address
//   rdata  read data, valid the cycle after re
module hrm_mmrx_tpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hrm_mmrx.sv
// hrm_mmrx
//   HRM MCU receive memory manager. Demultiplexes framed slink words by
//   packet number into per-slot ping-pong banks and presents the newest
//   complete frame of each slot to the CPU-side reader through a
//   lock/release handshake.
// Ports:
//   clk_12_5m, rst_12_5m      clock, asynchronous active-high reset
//   slink_mmrx_dval/_data     input words: [17]=SOP [16]=EOP [15:0]=payload,
//                             header payload [11:8]=packet number
//   rd_start, rd_pkt_num      lock the ready bank of the selected slot
//   rd_en                     read next word of the locked bank
//   rd_done                   release lock, clear the slot's pkt_vld
//   rd_dval, rd_data          read data (0 beyond rd_len)
//   rd_len                    word count of the locked frame
//   pkt_vld                   per slot: unread complete frame present
//   drop_cnt                  saturating count of dropped frames
// Build option:
//   HRM_MMRX_CHKSUM_CHK_EN    last word of a frame is a mod-2^16 checksum of
//                             all prior words; mismatching frames are dropped
//                             and rd_len excludes the checksum word.
module hrm_mmrx
  import hrm_mmrx_pkg::*;
#(
  parameter int NUM_PKT = 4,
  parameter int DEPTH_W = 8,
  parameter int LEN_W   = 9
) (
  input  logic               clk_12_5m,
  input  logic               rst_12_5m,
  input  logic               slink_mmrx_dval,
  input  logic [17:0]        slink_mmrx_data,
  input  logic               rd_start,
  input  logic [3:0]         rd_pkt_num,
  input  logic               rd_en,
  input  logic               rd_done,
  output logic               rd_dval,
  output logic [15:0]        rd_data,
  output logic [LEN_W-1:0]   rd_len,
  output logic [NUM_PKT-1:0] pkt_vld,
  output logic [7:0]         drop_cnt
);

  localparam int SLOT_W = (NUM_PKT > 1) ? $clog2(NUM_PKT) : 1;
  localparam int ADDR_W = SLOT_W + 1 + DEPTH_W;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  wr_state_t            wr_state;
  logic [SLOT_W-1:0]    wr_slot;
  logic                 wr_bank;
  logic [DEPTH_W-1:0]   wr_addr;

  logic                 lock_act;
  logic [SLOT_W-1:0]    lock_slot;
  logic                 lock_bank;
  logic [LEN_W-1:0]     rd_addr;
  logic [NUM_PKT-1:0]   ready_bank;
  logic [LEN_W-1:0]     len_mem [NUM_PKT][2];

  logic                 rd_dval_p1;
  logic                 rd_past_p1;
  logic [15:0]          ram_q;

  // Input word decode
  logic [15:0]          payload;
  logic                 word_sop, word_eop;
  logic [3:0]           hdr_pkt;
  logic                 hdr_ok;
  logic [SLOT_W-1:0]    hdr_slot;
  logic                 hdr_bank;

  assign payload  = slink_mmrx_data[15:0];
  assign word_sop = slink_mmrx_dval & slink_mmrx_data[SOP_BIT];
  assign word_eop = slink_mmrx_dval & slink_mmrx_data[EOP_BIT];
  assign hdr_pkt  = slink_mmrx_data[PKT_MSB:PKT_LSB];
  assign hdr_ok   = 32'(hdr_pkt) < NUM_PKT;
  assign hdr_slot = hdr_pkt[SLOT_W-1:0];
  // Write into whichever bank the reader is not holding; when the slot is
  // not locked, keep the last committed frame and use the other bank.
  assign hdr_bank = (lock_act && lock_slot == hdr_slot) ? ~lock_bank : ~ready_bank[hdr_slot];

  logic                 new_start, bad_start, cont_word, abort_frm, overflow;
  logic [SLOT_W-1:0]    cur_slot;
  logic                 cur_bank;
  logic [DEPTH_W-1:0]   cur_addr;
  logic [LEN_W-1:0]     cur_len;
  logic                 end_try, chk_ok, commit, chk_drop;
  logic [1:0]           drop_inc;

  assign new_start = word_sop & hdr_ok  & (wr_state != WR_DROP);
  assign bad_start = word_sop & ~hdr_ok & (wr_state != WR_DROP);
  assign cont_word = slink_mmrx_dval & ~slink_mmrx_data[SOP_BIT] & (wr_state == WR_DATA);
  assign abort_frm = word_sop & (wr_state == WR_DATA);
  assign overflow  = cont_word & ~slink_mmrx_data[EOP_BIT] & (wr_addr == '1);

  assign cur_slot  = new_start ? hdr_slot : wr_slot;
  assign cur_bank  = new_start ? hdr_bank : wr_bank;
  assign cur_addr  = new_start ? '0 : wr_addr;
  assign end_try   = word_eop & (new_start | cont_word);

`ifdef HRM_MMRX_CHKSUM_CHK_EN
  logic [15:0] csum;
  logic [15:0] prior_sum;

  always_ff @(posedge clk_12_5m) begin
    if (new_start)      csum <= payload;
    else if (cont_word) csum <= csum + payload;
  end

  assign prior_sum = new_start ? 16'h0000 : csum;
  assign chk_ok    = (prior_sum == payload);
  assign cur_len   = LEN_W'(cur_addr);
`else
  assign chk_ok    = 1'b1;
  assign cur_len   = LEN_W'(cur_addr) + LEN_W'(1);
`endif

  assign commit   = end_try & chk_ok;
  assign chk_drop = end_try & ~chk_ok;
  assign drop_inc = 2'(abort_frm) + 2'(bad_start) + 2'(overflow) + 2'(chk_drop);

  // Write FSM
  always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
    if (rst_12_5m) begin
      wr_state <= WR_IDLE;
      wr_slot  <= '0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= sat_add8(drop_cnt, drop_inc);
      if (new_start) begin
        wr_slot  <= hdr_slot;
        wr_bank  <= hdr_bank;
        wr_addr  <= DEPTH_W'(1);
        wr_state <= word_eop ? WR_IDLE : WR_DATA;
      end else if (bad_start) begin
        wr_state <= word_eop ? WR_IDLE : WR_DROP;
      end else if (cont_word) begin
        if (word_eop)           wr_state <= WR_IDLE;
        else if (wr_addr == '1) wr_state <= WR_DROP;
        else                    wr_addr  <= wr_addr + DEPTH_W'(1);
      end else if (wr_state == WR_DROP && word_eop) begin
        wr_state <= WR_IDLE;
      end
    end
  end

  always_ff @(posedge clk_12_5m) begin
    if (commit) len_mem[cur_slot][cur_bank] <= cur_len;
  end

  // Slot bookkeeping and read control
  logic [SLOT_W-1:0] rd_slot;
  logic              rd_start_ok;

  assign rd_slot     = rd_pkt_num[SLOT_W-1:0];
  assign rd_start_ok = rd_start & (32'(rd_pkt_num) < NUM_PKT) & pkt_vld[rd_slot];

  always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
    if (rst_12_5m) begin
      lock_act   <= 1'b0;
      lock_slot  <= '0;
      lock_bank  <= 1'b0;
      rd_addr    <= '0;
      rd_len     <= '0;
      pkt_vld    <= '0;
      ready_bank <= '0;
      rd_dval_p1 <= 1'b0;
      rd_past_p1 <= 1'b1;
    end else begin
      if (rd_done && lock_act) begin
        lock_act <= 1'b0;
        // A newer frame committed while locked remains unread.
        if (ready_bank[lock_slot] == lock_bank) pkt_vld[lock_slot] <= 1'b0;
      end
      if (rd_start_ok) begin
        lock_act  <= 1'b1;
        lock_slot <= rd_slot;
        lock_bank <= ready_bank[rd_slot];
        rd_addr   <= '0;
        rd_len    <= len_mem[rd_slot][ready_bank[rd_slot]];
      end else if (rd_en && rd_addr != '1) begin
        rd_addr <= rd_addr + LEN_W'(1);
      end
      // Commit is last so it wins over a simultaneous release.
      if (commit) begin
        pkt_vld[cur_slot]    <= 1'b1;
        ready_bank[cur_slot] <= cur_bank;
      end
      rd_dval_p1 <= rd_en;
      rd_past_p1 <= ~lock_act | (rd_addr >= rd_len);
    end
  end

  // Buffer RAM, read data returns with rd_dval_p1
  hrm_mmrx_tpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_tpram (
    .clk   (clk_12_5m),
    .we    (new_start | cont_word),
    .waddr (ADDR_W'(ram_addr(32'(cur_slot), 32'(cur_bank), 32'(cur_addr), DEPTH_W))),
    .wdata (payload),
    .re    (rd_en),
    .raddr (ADDR_W'(ram_addr(32'(lock_slot), 32'(lock_bank), 32'(rd_addr[DEPTH_W-1:0]), DEPTH_W))),
    .rdata (ram_q)
  );

  assign rd_dval = rd_dval_p1;
  assign rd_data = (rd_dval_p1 && !rd_past_p1) ? ram_q : 16'h0000;

endmodule

// File: tb/tb_hrm_mmrx.sv
// tb_hrm_mmrx
//   Directed bench for hrm_mmrx: frame write/read, lock ping-pong, bad
//   packet number, oversize frame, mid-frame abort, commit vs release,
//   drop counter saturation and mid-frame reset. Builds with or without
//   HRM_MMRX_CHKSUM_CHK_EN.
module tb_hrm_mmrx;

`ifdef HRM_MMRX_CHKSUM_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dval;
  logic [17:0] data;
  logic        rd_start;
  logic [3:0]  rd_pkt_num;
  logic        rd_en;
  logic        rd_done;
  logic        rd_dval;
  logic [15:0] rd_data;
  logic [8:0]  rd_len;
  logic [3:0]  pkt_vld;
  logic [7:0]  drop_cnt;

  int nvec = 0;
  int nmis = 0;
  int exp_drop = 0;

  logic [15:0] fr [0:3][0:299];
  int          flen [0:3];

  hrm_mmrx #(
    .NUM_PKT (4),
    .DEPTH_W (8),
    .LEN_W   (9)
  ) dut (
    .clk_12_5m       (clk),
    .rst_12_5m       (rst),
    .slink_mmrx_dval (dval),
    .slink_mmrx_data (data),
    .rd_start        (rd_start),
    .rd_pkt_num      (rd_pkt_num),
    .rd_en           (rd_en),
    .rd_done         (rd_done),
    .rd_dval         (rd_dval),
    .rd_data         (rd_data),
    .rd_len          (rd_len),
    .pkt_vld         (pkt_vld),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Header carries pkt in [11:8] and seed low byte; data words seed + i*0x0101.
  task automatic build(input int f, input logic [3:0] pkt, input logic [15:0] seed, input int n);
    logic [15:0] s;
    flen[f]  = n;
    fr[f][0] = {4'h0, pkt, seed[7:0]};
    s = fr[f][0];
    for (int i = 1; i < n; i++) begin
      fr[f][i] = seed + 16'(i) * 16'h0101;
      if (i < n - 1) s = s + fr[f][i];
    end
    if (CHK && n > 1) fr[f][n-1] = s;
  endtask

  task automatic send(input int f, input bit done_at_eop);
    for (int i = 0; i < flen[f]; i++) begin
      @(negedge clk);
      dval    = 1'b1;
      data    = {(i == 0), (i == flen[f] - 1), fr[f][i]};
      rd_done = done_at_eop && (i == flen[f] - 1);
    end
    @(negedge clk);
    dval    = 1'b0;
    data    = '0;
    rd_done = 1'b0;
  endtask

  task automatic send_partial(input int f, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      dval = 1'b1;
      data = {(i == 0), 1'b0, fr[f][i]};
    end
  endtask

  task automatic lock(input logic [3:0] slot, input int f);
    @(negedge clk);
    rd_start   = 1'b1;
    rd_pkt_num = slot;
    @(negedge clk);
    rd_start = 1'b0;
    check("rd_len", 32'(rd_len), 32'(CHK ? flen[f] - 1 : flen[f]));
  endtask

  task automatic read_frame(input int f, input int nrd);
    int elen;
    elen = CHK ? flen[f] - 1 : flen[f];
    for (int i = 0; i < nrd; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("rd_dval", 32'(rd_dval), 32'd1);
      check("rd_data", 32'(rd_data), (i < elen) ? 32'(fr[f][i]) : 32'd0);
    end
  endtask

  task automatic do_done();
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dval = 1'b0; data = '0;
    rd_start = 1'b0; rd_pkt_num = '0; rd_en = 1'b0; rd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pkt_vld", 32'(pkt_vld), 32'd0);
    check("rst_drop",    32'(drop_cnt), 32'd0);
    check("rst_rd_dval", 32'(rd_dval), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_len",  32'(rd_len), 32'd0);
    rst = 1'b0;

    // Basic frame on slot 2, read one word past the end
    build(0, 4'd2, 16'h0000, 5);
    send(0, 1'b0);
    check("t1_pkt_vld", 32'(pkt_vld), 32'b0100);
    lock(4'd2, 0);
    read_frame(0, 6);
    do_done();
    check("t1_released", 32'(pkt_vld), 32'd0);

    // Locked frame survives two newer frames on the same slot
    build(1, 4'd1, 16'h1100, 4);
    send(1, 1'b0);
    check("t2_pkt_vld", 32'(pkt_vld), 32'b0010);
    lock(4'd1, 1);
    build(2, 4'd1, 16'h2200, 3);
    send(2, 1'b0);
    build(3, 4'd1, 16'h3300, 6);
    send(3, 1'b0);
    check("t2_vld_locked", 32'(pkt_vld), 32'b0010);
    read_frame(1, 4);
    do_done();
    check("t2_vld_after_done", 32'(pkt_vld), 32'b0010);
    lock(4'd1, 3);
    read_frame(3, 6);
    do_done();
    check("t2_released", 32'(pkt_vld), 32'd0);

    // Out-of-range packet number
    build(0, 4'd7, 16'h7700, 3);
    send(0, 1'b0);
    exp_drop++;
    check("t3_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t3_pkt_vld", 32'(pkt_vld), 32'd0);

    // Oversize frame, then a normal one
    build(0, 4'd0, 16'h0A00, 300);
    send(0, 1'b0);
    exp_drop++;
    check("t4_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t4_pkt_vld", 32'(pkt_vld), 32'd0);
    build(1, 4'd0, 16'h4400, 10);
    send(1, 1'b0);
    check("t4_next_vld", 32'(pkt_vld), 32'b0001);
    check("t4_next_drop", 32'(drop_cnt), 32'(exp_drop));
    lock(4'd0, 1);
    read_frame(1, 10);
    do_done();
    check("t4_released", 32'(pkt_vld), 32'd0);

    // SOP mid-frame aborts; commit coincident with release keeps pkt_vld
    build(0, 4'd0, 16'h5500, 5);
    send_partial(0, 3);
    build(1, 4'd0, 16'h6600, 4);
    send(1, 1'b0);
    exp_drop++;
    check("t5_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t5_pkt_vld", 32'(pkt_vld), 32'b0001);
    lock(4'd0, 1);
    build(2, 4'd0, 16'h7700, 3);
    send(2, 1'b1);
    check("t5_vld_commit_wins", 32'(pkt_vld), 32'b0001);
    lock(4'd0, 2);
    read_frame(2, 3);
    do_done();
    check("t5_released", 32'(pkt_vld), 32'd0);

    // Single-word SOP&EOP frame
    build(0, 4'd3, 16'h00AB, 1);
    send(0, 1'b0);
`ifdef HRM_MMRX_CHKSUM_CHK_EN
    exp_drop++;
    check("t6_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t6_pkt_vld", 32'(pkt_vld), 32'd0);
`else
    check("t6_pkt_vld", 32'(pkt_vld), 32'b1000);
    lock(4'd3, 0);
    read_frame(0, 1);
    do_done();
    check("t6_released", 32'(pkt_vld), 32'd0);
`endif

`ifdef HRM_MMRX_CHKSUM_CHK_EN
    // Corrupted checksum
    build(0, 4'd1, 16'h1200, 4);
    fr[0][3] = fr[0][3] ^ 16'h0001;
    send(0, 1'b0);
    exp_drop++;
    check("t7_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t7_pkt_vld", 32'(pkt_vld), 32'd0);
`endif

    // Drop counter saturation with back-to-back bad single-word frames
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      dval = 1'b1;
      data = {2'b11, 16'h0700};
    end
    @(negedge clk);
    dval = 1'b0;
    data = '0;
    check("t8_drop_sat", 32'(drop_cnt), 32'hFF);
    check("t8_pkt_vld", 32'(pkt_vld), 32'd0);

    // Reset in the middle of a frame
    build(0, 4'd3, 16'h3300, 5);
    send_partial(0, 3);
    @(negedge clk);
    dval = 1'b0;
    data = '0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t9_pkt_vld", 32'(pkt_vld), 32'd0);
    check("t9_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    dval = 1'b1;
    data = {2'b01, 16'h1234};
    @(negedge clk);
    dval = 1'b0;
    data = '0;
    check("t9_stray_eop", 32'(pkt_vld), 32'd0);
    build(1, 4'd3, 16'h3400, 3);
    send(1, 1'b0);
    check("t9_after_rst_vld", 32'(pkt_vld), 32'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
